// File: rtl/fetch_pkg.sv
// Shared definitions for the WISC fetch stage.
//   INSTR_W : instruction / PC width
//   PC_INC  : PC step between sequential instructions
//   NOP     : encoding presented to decode when no instruction is valid
//   state_t : fetch control states
package fetch_pkg;

  localparam int              INSTR_W = 16;
  localparam logic [INSTR_W-1:0] PC_INC = 16'd2;
  localparam logic [INSTR_W-1:0] NOP    = 16'h0800;

  // ST_REQ   : normal fetching
  // ST_DRAIN : one memory response is still owed and must be thrown away
  // ST_HALT  : terminal until reset
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/dff.sv
// Generic register cell with synchronous active-high reset.
//   clk, rst : clock and synchronous reset
//   d        : next value
//   q        : registered value, RST_VAL while in reset
module dff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/fetch_skid.sv
// One-entry holding register for an {instr, pc} pair that arrived while the
// output slot was occupied and stalled.
//   clear   : drop any held entry (highest priority)
//   load    : capture d_instr/d_pc and mark valid
//   unload  : entry has been moved out; mark empty
//   valid, q_instr, q_pc : held entry
module fetch_skid
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               unload,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [INSTR_W-1:0] d_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] q_instr,
  output logic [INSTR_W-1:0] q_pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      q_instr <= NOP;
      q_pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch.sv
// WISC instruction fetch stage. Owns the architectural PC, reads the
// instruction memory over a request/done handshake and presents one
// instruction per cycle to decode.
//
// Handshakes:
//   memory : imem_rd is held high with a stable imem_addr until the cycle in
//            which imem_done is seen (done may come in the same cycle).
//   decode : an instruction is transferred on a cycle with
//            instr_valid && !stall; otherwise INSTR/PC/PC2 are held.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   imem_rd/addr/rdata/done: instruction memory interface
//   stall                  : decode back-pressure
//   redirect, redirect_pc  : load new PC, squash younger work
//   halt_in                : stop fetching permanently
//   INSTR, PC, PC2         : instruction to decode, its address, address+2
//   instr_valid            : INSTR/PC/PC2 valid
//   halted                 : fetch stopped until reset
//   err                    : sticky, misaligned redirect target seen
module fetch
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_rd,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_done,
  input  logic               stall,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  input  logic               halt_in,
  output logic [INSTR_W-1:0] INSTR,
  output logic [INSTR_W-1:0] PC,
  output logic [INSTR_W-1:0] PC2,
  output logic               instr_valid,
  output logic               halted,
  output logic               err
);

  // Control state, kept as named signals so checkers can bind to them.
  state_t             state_q, state_d;
  logic [1:0]         state_bits;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic               busy_q, busy_d;
  logic [INSTR_W-1:0] addr_q;
  logic               halt_pend_q, halt_pend_d;
  logic               err_q, err_set;

  logic               out_valid_q, out_valid_d;
  logic [INSTR_W-1:0] out_instr_q, out_pc_q;
  logic               out_load, out_from_skid;

  logic               skid_valid, skid_load, skid_unload, flush;
  logic [INSTR_W-1:0] skid_instr, skid_pc;

  logic               rd, consume;
  logic [INSTR_W-1:0] redir_even;

  assign consume    = out_valid_q && !stall;
  assign redir_even = {redirect_pc[INSTR_W-1:1], 1'b0};

  dff #(.WIDTH(INSTR_W), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .d(pc_d), .q(pc_q)
  );

  dff #(.WIDTH(2), .RST_VAL(ST_REQ)) u_state (
    .clk(clk), .rst(rst), .d(state_d), .q(state_bits)
  );
  assign state_q = state_t'(state_bits);

  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .load    (skid_load),
    .unload  (skid_unload),
    .d_instr (imem_rdata),
    .d_pc    (pc_q),
    .valid   (skid_valid),
    .q_instr (skid_instr),
    .q_pc    (skid_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rd            = 1'b0;
    busy_d        = 1'b0;
    halt_pend_d   = halt_pend_q;
    err_set       = 1'b0;
    out_valid_d   = out_valid_q;
    out_load      = 1'b0;
    out_from_skid = 1'b0;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    flush         = 1'b0;

    case (state_q)
      ST_REQ: begin
        // A new request is not started in a cycle that redirects or halts,
        // so no response for a dead address is ever left in flight.
        rd     = busy_q || (!redirect && !halt_in && !skid_valid &&
                            (!out_valid_q || !stall));
        busy_d = rd && !imem_done;
        if (redirect) begin
          pc_d        = redir_even;
          err_set     = redirect_pc[0];
          flush       = 1'b1;
          out_valid_d = 1'b0;
          halt_pend_d = 1'b0;
          state_d     = (busy_q && !imem_done) ? ST_DRAIN : ST_REQ;
        end else if (halt_in) begin
          flush       = 1'b1;
          out_valid_d = 1'b0;
          if (busy_q && !imem_done) begin
            state_d     = ST_DRAIN;
            halt_pend_d = 1'b1;
          end else begin
            state_d = ST_HALT;
          end
        end else begin
          if (rd && imem_done) pc_d = pc_q + PC_INC;
          if (consume && skid_valid) begin
            out_from_skid = 1'b1;
            skid_unload   = 1'b1;
            out_valid_d   = 1'b1;
          end else if (rd && imem_done && (!out_valid_q || consume)) begin
            out_load    = 1'b1;
            out_valid_d = 1'b1;
          end else if (consume) begin
            out_valid_d = 1'b0;
          end
          if (rd && imem_done && out_valid_q && !consume) skid_load = 1'b1;
        end
      end

      ST_DRAIN: begin
        rd     = 1'b1;
        busy_d = !imem_done;
        if (redirect) begin
          pc_d        = redir_even;
          err_set     = redirect_pc[0];
          halt_pend_d = 1'b0;
        end
        if (imem_done) begin
          state_d     = (halt_pend_q && !redirect) ? ST_HALT : ST_REQ;
          halt_pend_d = halt_pend_q && !redirect;
        end
      end

      ST_HALT: begin
        rd = 1'b0;
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      addr_q      <= RESET_PC;
      halt_pend_q <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP;
      out_pc_q    <= '0;
    end else begin
      busy_q      <= busy_d;
      halt_pend_q <= halt_pend_d;
      err_q       <= err_q | err_set;
      out_valid_q <= out_valid_d;
      // Latch the address of a request that stays outstanding so it holds
      // even if pc_q is redirected underneath it.
      if (rd && !busy_q) addr_q <= pc_q;
      if (out_from_skid) begin
        out_instr_q <= skid_instr;
        out_pc_q    <= skid_pc;
      end else if (out_load) begin
        out_instr_q <= imem_rdata;
        out_pc_q    <= pc_q;
      end
    end
  end

  assign imem_rd     = rd && !rst;
  assign imem_addr   = busy_q ? addr_q : pc_q;
  assign INSTR       = out_valid_q ? out_instr_q : NOP;
  assign PC          = out_pc_q;
  assign PC2         = out_pc_q + PC_INC;
  assign instr_valid = out_valid_q;
  assign halted      = (state_q == ST_HALT);
  assign err         = err_q;

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_in;
  logic [15:0] INSTR, PC, PC2;
  logic        instr_valid, halted, err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_done(imem_done),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_in(halt_in),
    .INSTR(INSTR), .PC(PC), .PC2(PC2),
    .instr_valid(instr_valid), .halted(halted), .err(err)
  );

  // ---------------- memory model ----------------
  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  int lat = 1;   // cycles imem_rd is high up to and including done
  int cnt = 0;

  assign imem_done  = imem_rd && (cnt == lat - 1);
  assign imem_rdata = mem_data(imem_addr);

  always @(posedge clk) begin
    if (rst || !imem_rd || imem_done) cnt <= 0;
    else                              cnt <= cnt + 1;
  end

  // Request stability: once raised without done, rd/addr must hold.
  logic        hold = 1'b0;
  logic [15:0] hold_addr = 16'h0;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        n_checks++;
        assert ({imem_rd, imem_addr} === {1'b1, hold_addr}) else begin
          n_errors++;
          $error("FAIL req_hold: rd/addr=%b/%h required 1/%h", imem_rd, imem_addr, hold_addr);
        end
      end
      hold      = imem_rd && !imem_done;
      hold_addr = imem_addr;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid && !stall) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $error("FAIL sb_extra: unexpected PC=%h consumed", PC);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          assert ({PC, INSTR, PC2} === {e, mem_data(e), e + 16'd2}) else begin
            n_errors++;
            $error("FAIL sb_instr: PC/INSTR/PC2=%h/%h/%h required %h/%h/%h",
                   PC, INSTR, PC2, e, mem_data(e), e + 16'd2);
          end
        end
      end else if (!instr_valid) begin
        n_checks++;
        assert (INSTR === 16'h0800) else begin
          n_errors++;
          $error("FAIL nop_idle: INSTR=%h required 0800", INSTR);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_rd",     {15'd0, imem_rd},     16'd0);
    chk("rst_instr",  INSTR,                16'h0800);
    chk("rst_pc",     PC,                   16'h0000);
    chk("rst_pc2",    PC2,                  16'h0002);
    chk("rst_valid",  {15'd0, instr_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted},      16'd0);
    chk("rst_err",    {15'd0, err},         16'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; halt_in = 1'b0;
    lat = 1;
    tick(); tick();
    chk_reset();

    // Phase 1: combinational memory, then a 2-cycle stall on PC 0x0004.
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0004); exp_q.push_back(16'h0006);
    rst = 1'b0; #1;
    chk("p1_first_rd",   {15'd0, imem_rd}, 16'd1);
    chk("p1_first_addr", imem_addr,        16'h0000);
    chk("p1_first_val",  {15'd0, instr_valid}, 16'd0);
    tick();
    chk("p1_pc0",   PC,        16'h0000);
    chk("p1_addr2", imem_addr, 16'h0002);
    tick();
    chk("p1_pc2",   PC,        16'h0002);
    chk("p1_addr4", imem_addr, 16'h0004);
    tick(); stall = 1'b1; #1;
    chk("p1_stall_rd_a", {15'd0, imem_rd}, 16'd0);
    chk("p1_stall_pc_a", PC, 16'h0004);
    tick();
    chk("p1_stall_rd_b", {15'd0, imem_rd}, 16'd0);
    chk("p1_stall_pc_b", PC, 16'h0004);
    chk("p1_stall_vld",  {15'd0, instr_valid}, 16'd1);
    tick(); stall = 1'b0; #1;
    chk("p1_resume_pc",   PC,        16'h0004);
    chk("p1_resume_addr", imem_addr, 16'h0006);
    tick();
    chk("p1_pc6", PC, 16'h0006);
    tick(); stall = 1'b1; #1;
    chk("p1_pc8", PC, 16'h0008);

    // Phase 2: 3-cycle memory latency, fetch restarted at 0x0002.
    tick(); lat = 3; redirect = 1'b1; redirect_pc = 16'h0002;
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0004);
    exp_q.push_back(16'h0006); exp_q.push_back(16'h0008);
    tick(); redirect = 1'b0; stall = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("p2_addr_hold", imem_addr, 16'h0002);
      chk("p2_no_valid",  {15'd0, instr_valid}, 16'd0);
      if (i < 2) tick();
    end
    tick();
    chk("p2_pulse1", {15'd0, instr_valid}, 16'd1);
    chk("p2_pulse1_pc", PC, 16'h0002);
    tick();
    chk("p2_gap_a", {15'd0, instr_valid}, 16'd0);
    chk("p2_gap_nop", INSTR, 16'h0800);
    tick();
    chk("p2_gap_b", {15'd0, instr_valid}, 16'd0);
    tick();
    chk("p2_pulse2", {15'd0, instr_valid}, 16'd1);
    chk("p2_pulse2_pc", PC, 16'h0004);

    // Phase 3: redirect to 0x0040 while 0x000A is outstanding.
    repeat (7) tick();
    redirect = 1'b1; redirect_pc = 16'h0040; #1;
    chk("p3_out_addr", imem_addr, 16'h000A);
    tick(); redirect = 1'b0; #1;
    chk("p3_drain_addr", imem_addr, 16'h000A);
    chk("p3_drain_vld",  {15'd0, instr_valid}, 16'd0);
    tick();
    chk("p3_new_addr", imem_addr, 16'h0040);
    chk("p3_new_rd",   {15'd0, imem_rd}, 16'd1);
    tick(); tick();
    chk("p3_wait_vld", {15'd0, instr_valid}, 16'd0);
    tick(); stall = 1'b1; #1;
    chk("p3_pc40", PC, 16'h0040);
    chk("p3_pc40_vld", {15'd0, instr_valid}, 16'd1);

    // Phase 4: halt_in together with redirect -> redirect wins.
    tick(); lat = 1; halt_in = 1'b1; redirect = 1'b1; redirect_pc = 16'h0020;
    exp_q.push_back(16'h0020); exp_q.push_back(16'h0022);
    tick(); halt_in = 1'b0; redirect = 1'b0; stall = 1'b0; #1;
    chk("p4_halted", {15'd0, halted}, 16'd0);
    chk("p4_addr",   imem_addr, 16'h0020);
    tick();
    chk("p4_pc20", PC, 16'h0020);
    tick(); stall = 1'b1; lat = 3; #1;
    chk("p4_pc22", PC, 16'h0022);

    // Phase 5: halt_in alone with a request outstanding.
    tick(); stall = 1'b0;
    tick(); halt_in = 1'b1; #1;
    chk("p5_busy_rd", {15'd0, imem_rd}, 16'd1);
    tick(); halt_in = 1'b0; #1;
    chk("p5_drain_halted", {15'd0, halted}, 16'd0);
    chk("p5_drain_addr", imem_addr, 16'h0024);
    tick();
    chk("p5_halted", {15'd0, halted}, 16'd1);
    chk("p5_rd_off", {15'd0, imem_rd}, 16'd0);
    redirect = 1'b1; redirect_pc = 16'h0101;
    tick(); redirect = 1'b0; #1;
    chk("p5_ign_halted", {15'd0, halted}, 16'd1);
    chk("p5_ign_rd",     {15'd0, imem_rd}, 16'd0);
    chk("p5_ign_err",    {15'd0, err}, 16'd0);
    chk("p5_ign_vld",    {15'd0, instr_valid}, 16'd0);
    tick();
    chk("p5_still_rd", {15'd0, imem_rd}, 16'd0);

    // Phase 6: reset out of HALT, misaligned redirect, PC2 wrap.
    stall = 1'b1; lat = 1; rst = 1'b1;
    tick();
    chk_reset();
    rst = 1'b0; #1;
    chk("p6_first_addr", imem_addr, 16'h0000);
    tick();
    chk("p6_pc0", PC, 16'h0000);
    redirect = 1'b1; redirect_pc = 16'h0031;
    tick(); redirect = 1'b0; #1;
    chk("p6_err",  {15'd0, err}, 16'd1);
    chk("p6_addr", imem_addr, 16'h0030);
    tick();
    chk("p6_pc30", PC, 16'h0030);
    exp_q.push_back(16'h0030); exp_q.push_back(16'h0032);
    stall = 1'b0;
    tick(); tick(); stall = 1'b1; #1;
    chk("p6_pc34", PC, 16'h0034);
    chk("p6_err_sticky", {15'd0, err}, 16'd1);
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick(); redirect = 1'b0; #1;
    chk("p6_addr_fffe", imem_addr, 16'hFFFE);
    tick();
    chk("p6_pc_fffe",  PC,        16'hFFFE);
    chk("p6_pc2_wrap", PC2,       16'h0000);
    chk("p6_addr_wrap", imem_addr, 16'h0000);

    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
